// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a synchronous instruction memory,
// buffers returned words and hands {pc, pc+4, inst} to decode. Optional counters: FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int                DBITS               = 32,
  parameter logic [DBITS-1:0]  START_PC            = 32'h40,
  parameter int                INST_SIZE           = 4,
  parameter int                IMEM_ADDR_BIT_WIDTH = 11,
  parameter int                QDEPTH              = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
  input  logic [31:0]                    imem_rdata,
  input  logic                           redirect_valid,
  input  logic [DBITS-1:0]               redirect_pc,
  input  logic                           dec_ready,
  output logic                           if_valid,
  output logic [DBITS-1:0]               if_pc,
  output logic [DBITS-1:0]               if_pc_plus4,
  output logic [31:0]                    if_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                    fetch_count,
  output logic [31:0]                    bubble_count
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [DBITS-1:0] pc;
  logic [DBITS-1:0] inflight_pc;
  logic             inflight;

  logic [DBITS-1:0] q_pc   [QDEPTH];
  logic [31:0]      q_inst [QDEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             has_head;
  logic             pop;
  logic             issue;
  logic [CW:0]      occ_after;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake: a transfer happens on a cycle where if_valid and dec_ready are both high;
  // while if_valid is high and dec_ready low the payload is held; a redirect masks if_valid.
  assign has_head    = (count != '0);
  assign if_valid    = has_head & ~redirect_valid;
  assign pop         = if_valid & dec_ready;
  assign if_pc       = has_head ? q_pc[head] : '0;
  assign if_pc_plus4 = has_head ? (q_pc[head] + DBITS'(INST_SIZE)) : '0;
  assign if_inst     = has_head ? q_inst[head] : '0;
  assign imem_addr   = pc[IMEM_ADDR_BIT_WIDTH+1:2];

  // Occupancy after this cycle's pop, counting the response still in flight; issuing
  // only below QDEPTH guarantees every returned word has a free slot.
  assign occ_after = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue     = (occ_after < (CW+1)'(QDEPTH)) & ~redirect_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= START_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush everything, including the response for the outstanding wrong-path address.
      pc       <= redirect_pc & ~DBITS'(3);
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (inflight) begin
        q_pc[tail]   <= inflight_pc;
        q_inst[tail] <= imem_rdata;
        tail         <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      count    <= count + CW'(inflight) - CW'(pop);
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + DBITS'(INST_SIZE);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (pop && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (dec_ready && !if_valid && !redirect_valid && (bubble_count != '1)) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact vector tables for the fixed sequences plus a
// scoreboard-checked random-stall stream; a second instance covers PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [10:0] imem_addr, w_addr;
  logic [31:0] imem_rdata, w_rdata;
  logic        redirect_valid, w_redirect_valid;
  logic [31:0] redirect_pc, w_redirect_pc;
  logic        dec_ready;
  logic        if_valid, w_valid;
  logic [31:0] if_pc, if_pc_plus4, if_inst;
  logic [31:0] w_pc, w_pc_plus4, w_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count, w_fetch_count, w_bubble_count;
`endif

  fetch_stage u_dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  fetch_stage #(.START_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset_n(reset_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .dec_ready(dec_ready),
    .if_valid(w_valid), .if_pc(w_pc), .if_pc_plus4(w_pc_plus4), .if_inst(w_inst)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(w_fetch_count), .bubble_count(w_bubble_count)
`endif
  );

  function automatic logic [31:0] word_at(input logic [10:0] a);
    return {16'hDEAD, 5'd0, a};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return word_at(pc[12:2]);
  endfunction

  // Synchronous instruction memories: data one cycle after the address.
  always @(posedge clk) begin
    imem_rdata <= word_at(imem_addr);
    w_rdata    <= word_at(w_addr);
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        ca;
    logic [10:0] eaddr;
    logic        cw;
    logic [31:0] ewpc;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc,
                     input logic ca, input logic [10:0] eaddr,
                     input logic cw, input logic [31:0] ewpc);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.ev = ev; v.epc = epc;
    v.ca = ca; v.eaddr = eaddr; v.cw = cw; v.ewpc = ewpc;
    tv.push_back(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One vector per cycle: drive just after the rising edge, check at the falling edge.
  task automatic run_vecs(input string tag);
    foreach (tv[i]) begin
      dec_ready      = tv[i].rdy;
      redirect_valid = tv[i].redir;
      redirect_pc    = tv[i].rpc;
      @(negedge clk);
      chk($sformatf("%s c%0d if_valid", tag, i), {31'd0, if_valid}, {31'd0, tv[i].ev});
      if (tv[i].ev) begin
        chk($sformatf("%s c%0d if_pc", tag, i), if_pc, tv[i].epc);
        chk($sformatf("%s c%0d if_pc_plus4", tag, i), if_pc_plus4, tv[i].epc + 32'd4);
        chk($sformatf("%s c%0d if_inst", tag, i), if_inst, exp_inst(tv[i].epc));
      end
      if (tv[i].ca)
        chk($sformatf("%s c%0d imem_addr", tag, i), {21'd0, imem_addr}, {21'd0, tv[i].eaddr});
      if (tv[i].cw) begin
        chk($sformatf("%s c%0d wrap valid", tag, i), {31'd0, w_valid}, 32'd1);
        chk($sformatf("%s c%0d wrap pc", tag, i), w_pc, tv[i].ewpc);
        chk($sformatf("%s c%0d wrap pc_plus4", tag, i), w_pc_plus4, tv[i].ewpc + 32'd4);
        chk($sformatf("%s c%0d wrap inst", tag, i), w_inst, exp_inst(tv[i].ewpc));
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
    tv.delete();
  endtask

  task automatic load_stream_table();
    add(1, 0, 0, 0, 0,        1, 11'h10, 0, 0);
    add(1, 0, 0, 0, 0,        1, 11'h11, 0, 0);
    add(1, 0, 0, 1, 32'h40,   1, 11'h12, 1, 32'hFFFF_FFF8);
    add(1, 0, 0, 1, 32'h44,   1, 11'h13, 1, 32'hFFFF_FFFC);
    add(1, 0, 0, 1, 32'h48,   0, 0,      1, 32'h0000_0000);
    add(1, 0, 0, 1, 32'h4C,   0, 0,      1, 32'h0000_0004);
  endtask

  initial begin
    int n_xfer;
    logic [31:0] e;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;

    // Reset state
    reset_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    chk("reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("reset if_pc", if_pc, 32'd0);
    chk("reset if_pc_plus4", if_pc_plus4, 32'd0);
    chk("reset if_inst", if_inst, 32'd0);
    chk("reset imem_addr", {21'd0, imem_addr}, 32'h10);
`ifdef FETCH_PERF_CNT_EN
    chk("reset fetch_count", fetch_count, 32'd0);
    chk("reset bubble_count", bubble_count, 32'd0);
`endif

    // Streaming from reset, plus wrap of the second instance
    do_reset();
    load_stream_table();
    run_vecs("stream");

    // Decode stalls six cycles after the first valid
    do_reset();
    add(1, 0, 0, 0, 0,      1, 11'h10, 0, 0);
    add(1, 0, 0, 0, 0,      1, 11'h11, 0, 0);
    for (int k = 0; k < 6; k++) add(0, 0, 0, 1, 32'h40, 1, 11'h12, 0, 0);
    add(1, 0, 0, 1, 32'h40, 1, 11'h12, 0, 0);
    add(1, 0, 0, 1, 32'h44, 1, 11'h13, 0, 0);
    add(1, 0, 0, 1, 32'h48, 1, 11'h14, 0, 0);
    add(1, 0, 0, 1, 32'h4C, 1, 11'h15, 0, 0);
    run_vecs("stall");

    // Redirect while 0x44 is queued and 0x48 in flight, coinciding with a would-be transfer;
    // target issues the cycle after the redirect and shows up two cycles after that.
    do_reset();
    add(1, 0, 0,      0, 0,      1, 11'h10, 0, 0);
    add(1, 0, 0,      0, 0,      1, 11'h11, 0, 0);
    add(1, 0, 0,      1, 32'h40, 1, 11'h12, 0, 0);
    add(1, 1, 32'h103, 0, 0,     1, 11'h13, 0, 0);
    add(1, 0, 0,      0, 0,      1, 11'h40, 0, 0);
    add(1, 0, 0,      0, 0,      1, 11'h41, 0, 0);
    add(1, 0, 0,      1, 32'h100, 1, 11'h42, 0, 0);
    add(1, 0, 0,      1, 32'h104, 0, 0,     0, 0);
    run_vecs("redirect");
`ifdef FETCH_PERF_CNT_EN
    chk("perf fetch_count", fetch_count, 32'd3);
    chk("perf bubble_count", bubble_count, 32'd4);
`endif

    // Back-to-back redirects: the second target wins
    do_reset();
    add(1, 0, 0,       0, 0,       1, 11'h10, 0, 0);
    add(1, 0, 0,       0, 0,       1, 11'h11, 0, 0);
    add(1, 0, 0,       1, 32'h40,  1, 11'h12, 0, 0);
    add(1, 1, 32'h200, 0, 0,       0, 0,      0, 0);
    add(1, 1, 32'h303, 0, 0,       1, 11'h80, 0, 0);
    add(1, 0, 0,       0, 0,       1, 11'hC0, 0, 0);
    add(1, 0, 0,       0, 0,       1, 11'hC1, 0, 0);
    add(1, 0, 0,       1, 32'h300, 0, 0,      0, 0);
    add(1, 0, 0,       1, 32'h304, 0, 0,      0, 0);
    run_vecs("redir2");

    // Random decode back-pressure, in-order stream checked through the scoreboard
    do_reset();
    for (int k = 0; k < 100; k++) exp_q.push_back(32'h40 + 32'(k) * 32'd4);
    n_xfer = 0;
    for (int c = 0; c < 80; c++) begin
      dec_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (if_valid && dec_ready) begin
        e = exp_q.pop_front();
        chk($sformatf("sb xfer%0d if_pc", n_xfer), if_pc, e);
        chk($sformatf("sb xfer%0d if_pc_plus4", n_xfer), if_pc_plus4, e + 32'd4);
        chk($sformatf("sb xfer%0d if_inst", n_xfer), if_inst, exp_inst(e));
        n_xfer++;
      end
      @(posedge clk);
      #1;
    end
    chk("sb progress", {31'd0, n_xfer >= 20}, 32'd1);

    // Fill the queue, then assert reset between clock edges
    dec_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("full if_valid", {31'd0, if_valid}, 32'd1);
    chk("full if_pc", if_pc, exp_q[0]);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("async reset if_pc", if_pc, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    load_stream_table();
    run_vecs("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
